// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_state_t   : handshake FSM states
//   fault_cause_t : encoding of o_FaultCauseM
//   F3_*          : funct3 access-size/sign codes
//   f3_legal()    : funct3 legality for a given direction and XLEN
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        FC_ILLEGAL  = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_BUSERR   = 2'b10,
        FC_TIMEOUT  = 2'b11
    } fault_cause_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Unsigned variants exist only for loads; D/WU only on RV64.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store,
                                      input logic is_rv64);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_D:             f3_legal = is_rv64;
            F3_BU, F3_HU:     f3_legal = !is_store;
            F3_WU:            f3_legal = !is_store && is_rv64;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane formatting for the load/store unit.
//   i_funct3 : access size / sign code
//   i_off    : byte offset within the bus word
//   i_wdata  : right-aligned store data   -> o_wdata : lane-replicated store data
//   (size)   : -> o_be : byte enables shifted to the offset
//   i_rdata  : raw bus read data          -> o_rdata : extracted and extended load data
module lsu_align #(
    parameter  int unsigned XLEN  = 32,
    localparam int unsigned NB    = XLEN / 8,
    localparam int unsigned OFF_W = $clog2(NB)
) (
    input  logic [2:0]       i_funct3,
    input  logic [OFF_W-1:0] i_off,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [XLEN-1:0]  i_rdata,
    output logic [NB-1:0]    o_be,
    output logic [XLEN-1:0]  o_wdata,
    output logic [XLEN-1:0]  o_rdata
);
    logic [NB-1:0]   size_mask;
    logic [XLEN-1:0] shifted;

    // Store side: byte mask and replication by access size.
    always_comb begin
        size_mask = '0;
        o_wdata   = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                size_mask = NB'(8'h01);
                o_wdata   = {NB{i_wdata[7:0]}};
            end
            2'b01: begin
                size_mask = NB'(8'h03);
                o_wdata   = {(NB / 2){i_wdata[15:0]}};
            end
            2'b10: begin
                size_mask = NB'(8'h0F);
                o_wdata   = {(XLEN / 32){i_wdata[31:0]}};
            end
            default: begin
                size_mask = NB'(8'hFF);
                o_wdata   = i_wdata;
            end
        endcase
        o_be = size_mask << i_off;
    end

    // Load side: move the addressed bytes to bit 0, then extend; funct3[2] selects zero-extension.
    always_comb begin
        shifted = i_rdata >> {i_off, 3'b000};
        case (i_funct3[1:0])
            2'b00:   o_rdata = i_funct3[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            2'b01:   o_rdata = i_funct3[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            2'b10:   o_rdata = i_funct3[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: o_rdata = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_handshake.sv
// Memory-stage load/store unit driving a valid/ready data bus with variable latency.
//   clk, rst              : clock, asynchronous active-high reset
//   i_MemReqM..i_WriteDataM : M-stage access request from the data path
//   o_StallM              : hold the pipeline while a transaction is outstanding
//   o_LoadDataM/ValidM    : extended load result, valid for one cycle in DONE
//   o_FaultM/CauseM       : fault pulse (illegal, misaligned, bus error, timeout)
//   o_mem_* / i_mem_*     : bus request channel and response channel
module lsu_handshake #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_MemReqM,
    input  logic                i_MemWriteM,
    input  logic [2:0]          i_funct3M,
    input  logic [ADDR_W-1:0]   i_AddrM,
    input  logic [XLEN-1:0]     i_WriteDataM,
    output logic                o_StallM,
    output logic [XLEN-1:0]     o_LoadDataM,
    output logic                o_LoadValidM,
    output logic                o_FaultM,
    output logic [1:0]          o_FaultCauseM,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [XLEN-1:0]     o_mem_wdata,
    output logic [XLEN/8-1:0]   o_mem_be,
    input  logic                i_mem_ready,
    input  logic                i_mem_rvalid,
    input  logic [XLEN-1:0]     i_mem_rdata,
    input  logic                i_mem_err
);
    import lsu_pkg::*;

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NB-1:0]     be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [XLEN-1:0]   ld_data_q, ld_data_d;
    logic              fault_q, fault_d;
    fault_cause_t      cause_q, cause_d;

    logic [OFF_W-1:0]  req_off;
    logic [OFF_W-1:0]  low_mask;
    logic              req_legal;
    logic              req_misalign;
    logic              to_hit;
    logic              stall_c;
    logic              fault_c;
    fault_cause_t      cause_c;

    logic [2:0]        al_funct3;
    logic [OFF_W-1:0]  al_off;
    logic [NB-1:0]     al_be;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;

    assign req_off = i_AddrM[OFF_W-1:0];

    // Decode the incoming request: legality and natural alignment.
    always_comb begin
        req_legal = f3_legal(i_funct3M, i_MemWriteM, XLEN == 64);
        case (i_funct3M[1:0])
            2'b00:   low_mask = '0;
            2'b01:   low_mask = OFF_W'(1);
            2'b10:   low_mask = OFF_W'(3);
            default: low_mask = OFF_W'(7);
        endcase
        req_misalign = |(req_off & low_mask);
    end

    // Store formatting uses the live request in IDLE; load extraction uses the captured access.
    assign al_funct3 = (state_q == IDLE) ? i_funct3M : funct3_q;
    assign al_off    = (state_q == IDLE) ? req_off   : off_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_funct3 (al_funct3),
        .i_off    (al_off),
        .i_wdata  (i_WriteDataM),
        .i_rdata  (i_mem_rdata),
        .o_be     (al_be),
        .o_wdata  (al_wdata),
        .o_rdata  (al_rdata)
    );

    assign to_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and combinational stall/fault.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        off_d     = off_q;
        ld_data_d = ld_data_q;
        fault_d   = fault_q;
        cause_d   = cause_q;
        stall_c   = 1'b0;
        fault_c   = 1'b0;
        cause_c   = FC_ILLEGAL;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                fault_d = 1'b0;
                if (i_MemReqM) begin
                    if (!req_legal) begin
                        fault_c = 1'b1;
                        cause_c = FC_ILLEGAL;
                    end else if (req_misalign) begin
                        fault_c = 1'b1;
                        cause_c = FC_MISALIGN;
                    end else begin
                        stall_c  = 1'b1;
                        we_d     = i_MemWriteM;
                        addr_d   = {i_AddrM[ADDR_W-1:OFF_W], OFF_W'(0)};
                        be_d     = al_be;
                        wdata_d  = al_wdata;
                        funct3_d = i_funct3M;
                        off_d    = req_off;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (TIMEOUT != 0) cnt_d = cnt_q + CNT_W'(1);
                if (to_hit) begin
                    fault_d = 1'b1;
                    cause_d = FC_TIMEOUT;
                    state_d = DONE;
                end else if (i_mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (TIMEOUT != 0) cnt_d = cnt_q + CNT_W'(1);
                // A response in the last allowed cycle still completes normally.
                if (i_mem_rvalid) begin
                    ld_data_d = al_rdata;
                    fault_d   = i_mem_err;
                    cause_d   = FC_BUSERR;
                    state_d   = DONE;
                end else if (to_hit) begin
                    fault_d = 1'b1;
                    cause_d = FC_TIMEOUT;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                if (fault_q) begin
                    fault_c = 1'b1;
                    cause_c = cause_q;
                end
            end
        endcase
    end

    // State and captured transaction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            off_q     <= '0;
            ld_data_q <= '0;
            fault_q   <= 1'b0;
            cause_q   <= FC_ILLEGAL;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            funct3_q  <= funct3_d;
            off_q     <= off_d;
            ld_data_q <= ld_data_d;
            fault_q   <= fault_d;
            cause_q   <= cause_d;
        end
    end

    // IDLE-cycle stall/fault depend on live inputs, so mask them while reset is held.
    assign o_StallM      = stall_c & ~rst;
    assign o_FaultM      = fault_c & ~rst;
    assign o_FaultCauseM = (fault_c && !rst) ? cause_c : 2'b00;
    assign o_LoadValidM  = (state_q == DONE) && !we_q && !fault_q;
    assign o_LoadDataM   = ld_data_q;
    assign o_mem_req     = (state_q == REQ);
    assign o_mem_we      = we_q;
    assign o_mem_addr    = addr_q;
    assign o_mem_be      = be_q;
    assign o_mem_wdata   = wdata_q;

endmodule

// File: tb/tb_lsu_handshake.sv
module tb_lsu_handshake;

    logic        clk;
    logic        rst;
    logic        i_MemReqM;
    logic        i_MemWriteM;
    logic [2:0]  i_funct3M;
    logic [31:0] i_AddrM;
    logic [31:0] i_WriteDataM;
    logic        o_StallM;
    logic [31:0] o_LoadDataM;
    logic        o_LoadValidM;
    logic        o_FaultM;
    logic [1:0]  o_FaultCauseM;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        i_mem_err;

    int n_cmp = 0;
    int n_err = 0;

    // Observations recorded by the access task.
    int          stall_cnt;
    logic        bus_req, bus_we, wait_req, done_stall, done_valid, done_fault;
    logic [31:0] bus_addr, bus_wdata, done_data;
    logic [3:0]  bus_be;
    logic [1:0]  done_cause;
    int          req_cycles;

    lsu_handshake #(.XLEN(32), .ADDR_W(32), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_MemReqM     (i_MemReqM),
        .i_MemWriteM   (i_MemWriteM),
        .i_funct3M     (i_funct3M),
        .i_AddrM       (i_AddrM),
        .i_WriteDataM  (i_WriteDataM),
        .o_StallM      (o_StallM),
        .o_LoadDataM   (o_LoadDataM),
        .o_LoadValidM  (o_LoadValidM),
        .o_FaultM      (o_FaultM),
        .o_FaultCauseM (o_FaultCauseM),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .o_mem_be      (o_mem_be),
        .i_mem_ready   (i_mem_ready),
        .i_mem_rvalid  (i_mem_rvalid),
        .i_mem_rdata   (i_mem_rdata),
        .i_mem_err     (i_mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Zero-wait access: ready in REQ, response in the following cycle.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
        stall_cnt = 0;
        @(negedge clk);
        i_MemReqM = 1'b1; i_MemWriteM = we; i_funct3M = f3; i_AddrM = addr;
        i_WriteDataM = wdata; i_mem_ready = 1'b1;
        #1 stall_cnt += int'(o_StallM);
        @(negedge clk);
        #1 stall_cnt += int'(o_StallM);
        bus_req = o_mem_req; bus_we = o_mem_we; bus_addr = o_mem_addr;
        bus_be = o_mem_be; bus_wdata = o_mem_wdata;
        @(negedge clk);
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = rdata; i_mem_err = err;
        #1 stall_cnt += int'(o_StallM);
        wait_req = o_mem_req;
        @(negedge clk);
        i_mem_rvalid = 1'b0; i_mem_err = 1'b0; i_MemReqM = 1'b0;
        #1 done_stall = o_StallM; done_valid = o_LoadValidM; done_data = o_LoadDataM;
        done_fault = o_FaultM; done_cause = o_FaultCauseM;
    endtask

    initial begin
        rst = 1'b1;
        i_MemReqM = 1'b0; i_MemWriteM = 1'b0; i_funct3M = 3'b000; i_AddrM = '0;
        i_WriteDataM = '0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        i_mem_err = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_stall", o_StallM, 0);
        chk("rst_req", o_mem_req, 0);
        chk("rst_valid", o_LoadValidM, 0);
        chk("rst_fault", o_FaultM, 0);
        chk("rst_addr", o_mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // SW 0x100
        access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
        chk("sw_stall_cycles", stall_cnt, 3);
        chk("sw_req", bus_req, 1);
        chk("sw_we", bus_we, 1);
        chk("sw_addr", bus_addr, 32'h100);
        chk("sw_be", bus_be, 4'b1111);
        chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
        chk("sw_wait_req", wait_req, 0);
        chk("sw_done_stall", done_stall, 0);
        chk("sw_done_valid", done_valid, 0);
        chk("sw_done_fault", done_fault, 0);

        // SB 0x103
        access(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1'b0);
        chk("sb_addr", bus_addr, 32'h100);
        chk("sb_be", bus_be, 4'b1000);
        chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);

        // SH 0x102
        access(1'b1, 3'b001, 32'h102, 32'hFFFF1234, 32'h0, 1'b0);
        chk("sh_be", bus_be, 4'b1100);
        chk("sh_wdata", bus_wdata, 32'h12341234);

        // LB / LBU 0x102
        access(1'b0, 3'b000, 32'h102, 32'h0, 32'h12F45678, 1'b0);
        chk("lb_stall_cycles", stall_cnt, 3);
        chk("lb_we", bus_we, 0);
        chk("lb_data", done_data, 32'hFFFFFFF4);
        chk("lb_valid", done_valid, 1);
        chk("lb_fault", done_fault, 0);
        access(1'b0, 3'b100, 32'h102, 32'h0, 32'h12F45678, 1'b0);
        chk("lbu_data", done_data, 32'h000000F4);
        chk("lbu_valid", done_valid, 1);

        // LH 0x100 negative, LHU 0x102
        access(1'b0, 3'b001, 32'h100, 32'h0, 32'h00008001, 1'b0);
        chk("lh_data", done_data, 32'hFFFF8001);
        access(1'b0, 3'b101, 32'h102, 32'h0, 32'h9ABC0000, 1'b0);
        chk("lhu_data", done_data, 32'h00009ABC);

        // LH 0x101 misaligned
        @(negedge clk);
        i_MemReqM = 1'b1; i_MemWriteM = 1'b0; i_funct3M = 3'b001; i_AddrM = 32'h101;
        #1;
        chk("mis_fault", o_FaultM, 1);
        chk("mis_cause", o_FaultCauseM, 2'b01);
        chk("mis_stall", o_StallM, 0);
        chk("mis_req", o_mem_req, 0);
        @(negedge clk); #1;
        chk("mis_req_next", o_mem_req, 0);
        i_MemReqM = 1'b0;
        #1 chk("mis_fault_drop", o_FaultM, 0);

        // Illegal store SBU and illegal load funct3 011 on RV32
        @(negedge clk);
        i_MemReqM = 1'b1; i_MemWriteM = 1'b1; i_funct3M = 3'b100; i_AddrM = 32'h0;
        #1;
        chk("ill_st_fault", o_FaultM, 1);
        chk("ill_st_cause", o_FaultCauseM, 2'b00);
        chk("ill_st_stall", o_StallM, 0);
        i_MemWriteM = 1'b0; i_funct3M = 3'b011;
        #1;
        chk("ill_ld_fault", o_FaultM, 1);
        chk("ill_ld_cause", o_FaultCauseM, 2'b00);
        @(negedge clk); #1;
        chk("ill_req", o_mem_req, 0);
        i_MemReqM = 1'b0;

        // LW timeout with ready held low
        @(negedge clk);
        i_MemReqM = 1'b1; i_MemWriteM = 1'b0; i_funct3M = 3'b010; i_AddrM = 32'h0;
        i_mem_ready = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (o_mem_req) req_cycles++;
            else break;
        end
        chk("to_req_cycles", req_cycles, 16);
        chk("to_fault", o_FaultM, 1);
        chk("to_cause", o_FaultCauseM, 2'b11);
        chk("to_valid", o_LoadValidM, 0);
        chk("to_stall", o_StallM, 0);
        i_MemReqM = 1'b0;

        // LW bus error
        access(1'b0, 3'b010, 32'h4, 32'h0, 32'hCAFEF00D, 1'b1);
        chk("err_fault", done_fault, 1);
        chk("err_cause", done_cause, 2'b10);
        chk("err_valid", done_valid, 0);

        // Reset during WAIT
        @(negedge clk);
        i_MemReqM = 1'b1; i_MemWriteM = 1'b0; i_funct3M = 3'b010; i_AddrM = 32'h200;
        i_WriteDataM = 32'h0; i_mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("wr_wait_stall", o_StallM, 1);
        chk("wr_wait_req", o_mem_req, 0);
        rst = 1'b1;
        #1;
        chk("ar_stall", o_StallM, 0);
        chk("ar_req", o_mem_req, 0);
        chk("ar_addr", o_mem_addr, 0);
        chk("ar_be", o_mem_be, 0);
        chk("ar_we", o_mem_we, 0);
        chk("ar_data", o_LoadDataM, 0);
        chk("ar_valid", o_LoadValidM, 0);
        chk("ar_fault", o_FaultM, 0);
        chk("ar_cause", o_FaultCauseM, 0);
        @(negedge clk);
        i_MemReqM = 1'b0; i_mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        access(1'b0, 3'b010, 32'h200, 32'h0, 32'h01234567, 1'b0);
        chk("post_addr", bus_addr, 32'h200);
        chk("post_stall_cycles", stall_cnt, 3);
        chk("post_data", done_data, 32'h01234567);
        chk("post_valid", done_valid, 1);
        chk("post_fault", done_fault, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_handshake.md
Name: lsu_handshake

Overview:
- Parametrised load/store unit that replaces the single-cycle data-memory port of the pipelined RISC-V core.
- Sits in the Memory stage between the data path and a valid/ready data bus with variable latency.
- Performs byte/halfword/word (and doubleword when XLEN=64) alignment and sign/zero extension.
- Raises a stall to the hazard unit while a bus transaction is outstanding, and reports misalignment, bus-error and timeout faults.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT, 16, maximum cycles spent in REQ+WAIT before a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- i_MemReqM  in  1  M-stage instruction is a load or store.
- i_MemWriteM  in  1  1 = store, 0 = load.
- i_funct3M  in  3  access size and sign.
- i_AddrM  in  ADDR_W  byte address (ALUResultM).
- i_WriteDataM  in  XLEN  store data, right-aligned.
- o_StallM  out  1  to hazard unit; freezes F/D/E/M and bubbles W.
- o_LoadDataM  out  XLEN  extended load result.
- o_LoadValidM  out  1  o_LoadDataM valid this cycle.
- o_FaultM  out  1  fault pulse.
- o_FaultCauseM  out  2  fault cause, meaningful only when o_FaultM=1.
- o_mem_req  out  1  bus request valid.
- o_mem_we  out  1  bus write.
- o_mem_addr  out  ADDR_W  bus address, aligned down to XLEN/8 bytes.
- o_mem_wdata  out  XLEN  lane-replicated store data.
- o_mem_be  out  XLEN/8  byte enables.
- i_mem_ready  in  1  bus accepts the request.
- i_mem_rvalid  in  1  response valid; read data or write acknowledge.
- i_mem_rdata  in  XLEN  read data.
- i_mem_err  in  1  bus error, qualified by i_mem_rvalid.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Reset asserted mid-transaction aborts immediately; no fault is reported.
- funct3 decoding:
  - 000 B, 001 H, 010 W, 011 D (only when XLEN=64), 100 BU, 101 HU, 110 WU (only when XLEN=64).
  - For stores only B/H/W/D are legal.
  - Any other code is illegal, cause 00.
- Offset = addr[log2(XLEN/8)-1:0]. An access is misaligned when the offset is not a multiple of the access size; cause 01.
- FSM state IDLE:
  - If i_MemReqM and the access is illegal or misaligned: o_FaultM=1 for that cycle, no stall, no bus request, remain in IDLE.
  - If i_MemReqM and the access is legal: o_StallM=1 combinationally; register we, aligned address, be and wdata; go to REQ.
- FSM state REQ:
  - o_mem_req=1, o_StallM=1.
  - All bus outputs stay stable until i_mem_ready.
  - Request with i_mem_ready=1 in the same cycle goes to WAIT.
  - i_mem_rvalid is ignored in REQ; a response is never earlier than the cycle after acceptance.
- FSM state WAIT:
  - o_mem_req=0, o_StallM=1.
  - On i_mem_rvalid: capture the extended data and the error flag, then go to DONE.
- FSM state DONE (exactly one cycle):
  - o_StallM=0.
  - Load without error: o_LoadValidM=1.
  - If an error was flagged: o_FaultM=1 with cause 10 and o_LoadValidM=0.
  - Next state is IDLE.
- Timeout:
  - The counter increments in REQ and WAIT.
  - If it reaches TIMEOUT-1 without completion, go to DONE with fault cause 11 and drop o_mem_req.
  - The counter clears in IDLE.
- Store formatting:
  - be = size mask << offset.
  - wdata = the low 8/16/32 bits of i_WriteDataM replicated across all lanes; full width for W on XLEN=32 and D on XLEN=64.
- Load formatting: rdata >> (8*offset), truncated to the access size, then sign- or zero-extended to XLEN.
- Zero-wait latency: any legal access stalls 3 cycles (IDLE, REQ, WAIT); the result is presented in DONE.
- DONE is followed by IDLE, so a new access in M is evaluated at the earliest in the cycle after DONE.
- A back-to-back access is never re-issued for the same instruction because the pipeline advances in DONE.

Decomposition:
- Package lsu_pkg:
  - lsu_state_t enum (IDLE, REQ, WAIT, DONE).
  - funct3 localparams F3_B .. F3_WU.
  - fault_cause_t (ILLEGAL=00, MISALIGN=01, BUSERR=10, TIMEOUT=11).
- Sub-module lsu_align: purely combinational; store lane replication and byte-enable generation plus load extract/extend. The FSM stays in lsu_handshake.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ready immediate, rvalid next cycle -> o_mem_addr=0x100, be=1111, wdata=0xDEADBEEF, o_StallM high 3 cycles, no fault.
- SB addr 0x103, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5, o_mem_addr=0x100.
- LB addr 0x102, rdata 0x12F45678 -> o_LoadDataM=0xFFFFFFF4, o_LoadValidM=1 in DONE. The same access as LBU -> 0x000000F4.
- LH addr 0x101 -> o_FaultM=1, cause 01, for one cycle; o_mem_req never asserted; o_StallM=0.
- LW with TIMEOUT=16 and i_mem_ready held 0 -> o_mem_req drops after 16 cycles; DONE has cause 11 and o_LoadValidM=0. Separately, rvalid with i_mem_err=1 -> cause 10.
- rst asserted during WAIT -> all outputs 0 asynchronously. After release, LW addr 0x200 with rdata 0x01234567 returns 0x01234567 normally.
